// File: rtl/definitions_pkg.sv
`default_nettype none
// ============================================================================
// Package     : definitions_pkg
// Description : Shared SoC definitions. Holds the synchroniser state
//               encoding and the interrupt timer state encoding and
//               register map.
// Revision    : 1.0 - TimerState and TMR_* register indices added
// ============================================================================
package definitions_pkg;

   // Synchroniser handshake states used elsewhere in the SoC.
   typedef enum logic [1:0] {
      SYN_IDLE   = 2'd0,
      SYN_ACTIVE = 2'd1,
      SYN_DONE   = 2'd2
   } SynState;

   // Interrupt timer control FSM.
   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      RUNNING = 1'b1
   } TimerState;

   // Timer register indices (addr bus value).
   localparam logic [2:0] TMR_CTRL     = 3'd0;
   localparam logic [2:0] TMR_STATUS   = 3'd1;
   localparam logic [2:0] TMR_LOAD     = 3'd2;
   localparam logic [2:0] TMR_COUNT    = 3'd3;
   localparam logic [2:0] TMR_PRESCALE = 3'd4;

   // CTRL register bit positions.
   localparam int CTRL_EN_BIT     = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;
   localparam int CTRL_AR_BIT     = 2;

endpackage : definitions_pkg
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : timer_prescaler
// Description : Clock divider for irq_timer. Down-counter that emits a
//               single-cycle tick once every divisor+1 cycles while run is
//               high. restart reloads the counter from divisor.
// Ports       : clk      - system clock
//               reset    - asynchronous active-low reset
//               restart  - reload counter (timer start)
//               run      - count enable (timer running)
//               divisor  - division value P (period P+1)
//               tick     - one-cycle tick output
// Revision    : 1.0 - initial release
// ============================================================================
module timer_prescaler #(
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      restart,
   input  logic                      run,
   input  logic [PRESCALE_WIDTH-1:0] divisor,
   output logic                      tick
);

   logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;

   // Tick fires on the cycle the counter has run down to zero; the
   // counter is reloaded on that same edge so the period is divisor+1.
   assign tick = run & ~restart & (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = divisor;
      end else if (run) begin
         cnt_d = (cnt_q == '0) ? divisor : cnt_q - PRESCALE_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : timer_prescaler
`default_nettype wire

// File: rtl/irq_timer.sv
`default_nettype none
// ============================================================================
// Module      : irq_timer
// Description : Programmable down-counting interrupt timer with one-shot and
//               auto-reload modes and a write-1-to-clear expiry flag.
// Macro       : TIMER_PRESCALER_EN - when defined, adds the PRESCALE register
//               and a timer_prescaler instance; otherwise the timer ticks
//               every clock while running.
// Ports       : clk     - system clock
//               reset   - asynchronous active-low reset
//               cs      - active-low chip select
//               wr      - active-low write strobe (qualified by cs)
//               addr    - register index (0 CTRL .. 4 PRESCALE)
//               wr_data - write data
//               rd_data - combinational read data, 0 when not selected
//               irq     - active-high interrupt request
// Revision    : 1.0 - initial release
// ============================================================================
module irq_timer
   import definitions_pkg::*;
#(
   parameter int COUNT_WIDTH    = 32,
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        wr,
   input  logic [2:0]  addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        irq
);

   TimerState              state_q, state_d;
   logic                   en_q, en_d;
   logic                   irq_en_q, irq_en_d;
   logic                   ar_q, ar_d;
   logic                   expired_q, expired_d;
   logic [COUNT_WIDTH-1:0] load_q, load_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;

   logic        wr_en, wr_ctrl, wr_status, wr_load, wr_count;
   logic        start, tick;
   logic [31:0] prescale_rd;
   logic        unused_wr_data;

   assign wr_en     = ~cs & ~wr;
   assign wr_ctrl   = wr_en & (addr == TMR_CTRL);
   assign wr_status = wr_en & (addr == TMR_STATUS);
   assign wr_load   = wr_en & (addr == TMR_LOAD);
   assign wr_count  = wr_en & (addr == TMR_COUNT);
   assign start     = wr_ctrl & wr_data[CTRL_EN_BIT] & (state_q == IDLE);

   assign unused_wr_data = ^wr_data;

`ifdef TIMER_PRESCALER_EN
   logic [PRESCALE_WIDTH-1:0] prescale_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prescale_q <= '0;
      end else if (wr_en && (addr == TMR_PRESCALE)) begin
         prescale_q <= wr_data[PRESCALE_WIDTH-1:0];
      end
   end

   timer_prescaler #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH)
   ) u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .restart (start),
      .run     (state_q == RUNNING),
      .divisor (prescale_q),
      .tick    (tick)
   );

   assign prescale_rd = 32'(prescale_q);
`else
   logic [PRESCALE_WIDTH-1:0] unused_prescale;

   assign unused_prescale = '0;
   assign tick            = (state_q == RUNNING);
   assign prescale_rd     = '0;
`endif

   always_comb begin
      state_d   = state_q;
      en_d      = en_q;
      irq_en_d  = irq_en_q;
      ar_d      = ar_q;
      expired_d = expired_q;
      load_d    = load_q;
      count_d   = count_q;

      if (wr_load) begin
         load_d = wr_data[COUNT_WIDTH-1:0];
      end
      // Clear first so a same-cycle expiry below overrides it.
      if (wr_status && wr_data[0]) begin
         expired_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUNNING;
               count_d = load_q;
            end
         end
         RUNNING: begin
            if (tick) begin
               if (count_q != '0) begin
                  count_d = count_q - COUNT_WIDTH'(1);
               end else begin
                  expired_d = 1'b1;
                  if (ar_q) begin
                     count_d = load_q;
                  end else begin
                     en_d    = 1'b0;
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A CTRL write takes precedence over a same-cycle one-shot stop.
      if (wr_ctrl) begin
         en_d     = wr_data[CTRL_EN_BIT];
         irq_en_d = wr_data[CTRL_IRQ_EN_BIT];
         ar_d     = wr_data[CTRL_AR_BIT];
         state_d  = wr_data[CTRL_EN_BIT] ? RUNNING : IDLE;
      end
      if (wr_count) begin
         count_d = wr_data[COUNT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         en_q      <= 1'b0;
         irq_en_q  <= 1'b0;
         ar_q      <= 1'b0;
         expired_q <= 1'b0;
         load_q    <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         en_q      <= en_d;
         irq_en_q  <= irq_en_d;
         ar_q      <= ar_d;
         expired_q <= expired_d;
         load_q    <= load_d;
         count_q   <= count_d;
      end
   end

   assign irq = expired_q & irq_en_q;

   always_comb begin
      rd_data = '0;
      if (!cs) begin
         case (addr)
            TMR_CTRL:     rd_data = {29'b0, ar_q, irq_en_q, en_q};
            TMR_STATUS:   rd_data = {31'b0, expired_q};
            TMR_LOAD:     rd_data = 32'(load_q);
            TMR_COUNT:    rd_data = 32'(count_q);
            TMR_PRESCALE: rd_data = prescale_rd;
            default:      rd_data = '0;
         endcase
      end
   end

endmodule : irq_timer
`default_nettype wire

// File: tb/tb_irq_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_timer
// Description : Directed self-checking bench for irq_timer. Expected periods
//               account for whether TIMER_PRESCALER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_timer;

`ifdef TIMER_PRESCALER_EN
   localparam int HAS_PRE = 1;
`else
   localparam int HAS_PRE = 0;
`endif

   logic        clk;
   logic        reset;
   logic        cs;
   logic        wr;
   logic [2:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        irq;

   int tests;
   int failed;
   int period;

   irq_timer dut (
      .clk     (clk),
      .reset   (reset),
      .cs      (cs),
      .wr      (wr),
      .addr    (addr),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
      cs = 1'b0; wr = 1'b0; addr = a; wr_data = d;
      @(posedge clk);
      #1;
      cs = 1'b1; wr = 1'b1;
   endtask

   task automatic chk_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
      cs = 1'b0; wr = 1'b1; addr = a;
      #1;
      check(tag, rd_data, exp);
      cs = 1'b1;
   endtask

   task automatic chk_irq(input string tag, input logic exp);
      check(tag, {31'b0, irq}, {31'b0, exp});
   endtask

   initial begin
      tests = 0; failed = 0;
      reset = 1'b0; cs = 1'b1; wr = 1'b1; addr = '0; wr_data = '0;

      // Reset state
      step(2);
      chk_irq("rst_irq", 1'b0);
      chk_reg("rst_ctrl", 3'd0, 32'h0);
      chk_reg("rst_status", 3'd1, 32'h0);
      chk_reg("rst_count", 3'd3, 32'h0);
      reset = 1'b1;
      step(1);
      check("cs_high_rd", rd_data, 32'h0);

      // One-shot: LOAD=5, P=0, CTRL=011 -> expiry 6 cycles after start
      wr_reg(3'd4, 32'd0);
      wr_reg(3'd2, 32'd5);
      chk_reg("load_rb", 3'd2, 32'd5);
      wr_reg(3'd0, 32'b011);
      step(5);
      chk_irq("os_irq_pre", 1'b0);
      chk_reg("os_count_pre", 3'd3, 32'd0);
      step(1);
      chk_irq("os_irq", 1'b1);
      chk_reg("os_status", 3'd1, 32'd1);
      chk_reg("os_ctrl_en0", 3'd0, 32'b010);
      step(3);
      chk_reg("os_count_hold", 3'd3, 32'd0);
      wr_reg(3'd1, 32'd0);
      chk_irq("w0c_noeffect", 1'b1);
      wr_reg(3'd1, 32'd1);
      chk_irq("w1c_irq", 1'b0);

      // Auto-reload: LOAD=3, PRESCALE=2 -> period 4*(P+1)
      period = 4 * (HAS_PRE ? 3 : 1);
      wr_reg(3'd2, 32'd3);
      wr_reg(3'd4, 32'd2);
      wr_reg(3'd0, 32'b111);
      step(period - 1);
      chk_irq("ar_irq_pre1", 1'b0);
      step(1);
      chk_irq("ar_irq1", 1'b1);
      wr_reg(3'd1, 32'd1);
      chk_irq("ar_gap", 1'b0);
      step(period - 2);
      chk_irq("ar_irq_pre2", 1'b0);
      step(1);
      chk_irq("ar_irq2", 1'b1);
      chk_reg("ar_reload", 3'd3, 32'd3);

      // Clear issued on the exact expiry edge: EXPIRED must stay set
      step(period - 1);
      wr_reg(3'd1, 32'd1);
      chk_reg("clr_race_status", 3'd1, 32'd1);
      chk_irq("clr_race_irq", 1'b1);
      wr_reg(3'd0, 32'd0);
      wr_reg(3'd1, 32'd1);
      chk_irq("stopped_irq", 1'b0);

      // LOAD rewrite while running (P=0, IRQ disabled)
      wr_reg(3'd4, 32'd0);
      wr_reg(3'd2, 32'd10);
      wr_reg(3'd0, 32'b101);
      step(3);
      chk_reg("lr_count7", 3'd3, 32'd7);
      wr_reg(3'd2, 32'd2);
      chk_reg("lr_count6", 3'd3, 32'd6);
      step(6);
      chk_reg("lr_status_pre", 3'd1, 32'd0);
      step(1);
      chk_reg("lr_status", 3'd1, 32'd1);
      chk_reg("lr_newload", 3'd3, 32'd2);
      chk_irq("lr_irq_masked", 1'b0);
      wr_reg(3'd1, 32'd1);
      step(1);
      chk_reg("lr_status2_pre", 3'd1, 32'd0);
      step(1);
      chk_reg("lr_status2", 3'd1, 32'd1);

      // COUNT write overrides the decrement
      wr_reg(3'd3, 32'd40);
      chk_reg("cnt_write", 3'd3, 32'd40);
      wr_reg(3'd0, 32'd0);
      wr_reg(3'd1, 32'd1);

      // Reserved address
      wr_reg(3'd5, 32'hFFFF_FFFF);
      chk_reg("rsv_rd", 3'd5, 32'h0);
      chk_reg("rsv_ctrl", 3'd0, 32'h0);

      // PRESCALE=9, LOAD=4 -> 5*(P+1) cycles
      period = 5 * (HAS_PRE ? 10 : 1);
      wr_reg(3'd4, 32'd9);
      chk_reg("pre_rd", 3'd4, HAS_PRE ? 32'd9 : 32'd0);
      wr_reg(3'd2, 32'd4);
      wr_reg(3'd0, 32'b011);
      step(period - 1);
      chk_irq("pre_irq_pre", 1'b0);
      step(1);
      chk_irq("pre_irq", 1'b1);
      wr_reg(3'd1, 32'd1);

      // Reset mid-run
      wr_reg(3'd4, 32'd0);
      wr_reg(3'd2, 32'd3);
      wr_reg(3'd0, 32'b111);
      step(2);
      reset = 1'b0;
      #1;
      chk_irq("mid_rst_irq", 1'b0);
      chk_reg("mid_rst_count", 3'd3, 32'd0);
      step(1);
      reset = 1'b1;
      step(10);
      chk_reg("post_rst_ctrl", 3'd0, 32'd0);
      chk_reg("post_rst_status", 3'd1, 32'd0);
      chk_reg("post_rst_load", 3'd2, 32'd0);
      chk_reg("post_rst_count", 3'd3, 32'd0);
      chk_irq("post_rst_irq", 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule : tb_irq_timer
`default_nettype wire
